// File: rtl/imm_enc_pkg.sv
// ============================================================================
// Module   : imm_enc_pkg
// Purpose  : Shared types and opcode constants for the RV32I immediate encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_enc_pkg;

  typedef enum logic [1:0] {
    KIND_U  = 2'd0,
    KIND_I  = 2'd1,
    KIND_S  = 2'd2,
    KIND_LI = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    HOLD_HI = 2'd2
  } state_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI  = 3'b000;

endpackage

`default_nettype wire

// File: rtl/imm_pack.sv
// ============================================================================
// Module   : imm_pack
// Purpose  : Combinational U/I/S field packer. Range check on the immediate
//            is built only when IMM_ENC_RANGE_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_pack
  import imm_enc_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  kind_t w_kind;
  assign w_kind = kind_t'(kind);

  always_comb begin
    instr = 32'd0;
    case (w_kind)
      KIND_U:  instr = {imm[31:12], rd, opcode};
      KIND_S:  instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      default: instr = {imm[11:0], rs1, funct3, rd, opcode};
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  logic w_fits12;
  assign w_fits12 = (imm == {{20{imm[11]}}, imm[11:0]});

  always_comb begin
    err = 1'b0;
    case (w_kind)
      KIND_U:          err = (imm[11:0] != 12'd0);
      KIND_I, KIND_S:  err = !w_fits12;
      default:         err = 1'b0;
    endcase
  end
`else
  assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// Module   : imm_encoder
// Purpose  : Streams RV32I U/I/S words and LI (LUI/ADDI) expansions over a
//            valid/ready pair. Optional range check: IMM_ENC_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder
  import imm_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_kind,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_instr;
  logic [31:0] r_pend;
  logic        r_last;
  logic        r_err;
  logic        w_load;
  logic        w_adv;

  kind_t       w_kind;
  logic        w_li_fits;
  logic [19:0] w_hi;
  logic        w_two;
  logic [31:0] w_addi;

  logic [1:0]  w_p_kind;
  logic [6:0]  w_p_opc;
  logic [2:0]  w_p_f3;
  logic [4:0]  w_p_rs1;
  logic [31:0] w_p_imm;
  logic [31:0] w_p_instr;
  logic        w_p_err;

  assign w_kind    = kind_t'(in_kind);
  assign w_li_fits = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
  // ADDI sign-extends its immediate, so the upper part is rounded up when bit 11 is set
  assign w_hi      = in_imm[31:12] + {19'd0, in_imm[11]};
  assign w_two     = (w_kind == KIND_LI) && !w_li_fits && (in_imm[11:0] != 12'd0);
  assign w_addi    = {in_imm[11:0], in_rd, F3_ADDI, in_rd, OP_OPIMM};

  // LI is steered into the packer as either a single ADDI or the leading LUI
  always_comb begin
    w_p_kind = in_kind;
    w_p_opc  = in_opcode;
    w_p_f3   = in_funct3;
    w_p_rs1  = in_rs1;
    w_p_imm  = in_imm;
    if (w_kind == KIND_LI) begin
      if (w_li_fits) begin
        w_p_kind = KIND_I;
        w_p_opc  = OP_OPIMM;
        w_p_f3   = F3_ADDI;
        w_p_rs1  = 5'd0;
      end else begin
        w_p_kind = KIND_U;
        w_p_opc  = OP_LUI;
        w_p_imm  = {w_hi, 12'd0};
      end
    end
  end

  imm_pack u_pack (
    .kind   (w_p_kind),
    .opcode (w_p_opc),
    .funct3 (w_p_f3),
    .rd     (in_rd),
    .rs1    (w_p_rs1),
    .rs2    (in_rs2),
    .imm    (w_p_imm),
    .instr  (w_p_instr),
    .err    (w_p_err)
  );

  assign in_ready  = (r_state == IDLE) | ((r_state == HOLD) & out_ready);
  assign out_valid = (r_state != IDLE);
  assign out_instr = r_instr;
  assign out_last  = r_last;
  assign out_err   = r_err;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_adv        = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = w_two ? HOLD_HI : HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (in_valid) begin
            w_load       = 1'b1;
            w_state_next = w_two ? HOLD_HI : HOLD;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      HOLD_HI: begin
        if (out_ready) begin
          w_adv        = 1'b1;
          w_state_next = HOLD;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= 32'd0;
      r_pend  <= 32'd0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_load) begin
      r_instr <= w_p_instr;
      r_pend  <= w_addi;
      r_last  <= !w_two;
      r_err   <= w_p_err;
    end else if (w_adv) begin
      r_instr <= r_pend;
      r_last  <= 1'b1;
      r_err   <= 1'b0;
    end
  end

endmodule

`default_nettype wire
